// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared AluOp classes, funct codes, ALU control codes and sequencer states
package alu_ctrl_pkg;
  localparam logic [3:0] ALUOP_ADDI  = 4'b0000;
  localparam logic [3:0] ALUOP_ANDI  = 4'b0001;
  localparam logic [3:0] ALUOP_ORI   = 4'b0010;
  localparam logic [3:0] ALUOP_XORI  = 4'b0011;
  localparam logic [3:0] ALUOP_BEQ   = 4'b0100;
  localparam logic [3:0] ALUOP_BNE   = 4'b0110;
  localparam logic [3:0] ALUOP_BLEZ  = 4'b0111;
  localparam logic [3:0] ALUOP_RTYPE = 4'b1000;
  localparam logic [3:0] ALUOP_BGTZ  = 4'b1001;
  localparam logic [3:0] ALUOP_LUI   = 4'b1010;
  localparam logic [3:0] ALUOP_SLTI  = 4'b1011;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00010;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_NOR  = 5'b11000;
  localparam logic [4:0] ALU_ADD  = 5'b00100;
  localparam logic [4:0] ALU_SUB  = 5'b01100;
  localparam logic [4:0] ALU_MULT = 5'b01000;
  localparam logic [4:0] ALU_DIV  = 5'b01010;
  localparam logic [4:0] ALU_SLL  = 5'b10000;
  localparam logic [4:0] ALU_SRL  = 5'b10010;
  localparam logic [4:0] ALU_SRA  = 5'b10100;
  localparam logic [4:0] ALU_SLLV = 5'b10110;
  localparam logic [4:0] ALU_SRLV = 5'b11001;
  localparam logic [4:0] ALU_SLT  = 5'b01110;
  localparam logic [4:0] ALU_MFHI = 5'b01111;
  localparam logic [4:0] ALU_MFLO = 5'b00001;
  localparam logic [4:0] ALU_BNE  = 5'b11010;
  localparam logic [4:0] ALU_BLEZ = 5'b11100;
  localparam logic [4:0] ALU_BGTZ = 5'b11110;
  localparam logic [4:0] ALU_LUI  = 5'b00011;
  localparam logic [4:0] ALU_SLTI = 5'b00111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} seq_state_e;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational AluOp/funct to ALU control code table with mult/div/HI-LO flags
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] aluOp,
  input  logic [5:0] fnField,
  output logic [4:0] code,
  output logic       illegal,
  output logic       isMult,
  output logic       isDiv,
  output logic       isHiloRd
);
  always_comb begin
    code = 5'b00000;
    illegal = 1'b0;
    isMult = 1'b0;
    isDiv = 1'b0;
    isHiloRd = 1'b0;
    case (aluOp)
      ALUOP_RTYPE:
        case (fnField)
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_XOR:  code = ALU_XOR;
          FN_NOR:  code = ALU_NOR;
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_MULT: begin code = ALU_MULT; isMult = 1'b1; end
          FN_DIV:  begin code = ALU_DIV; isDiv = 1'b1; end
          FN_SLL:  code = ALU_SLL;
          FN_SRL:  code = ALU_SRL;
          FN_SRA:  code = ALU_SRA;
          FN_SLLV: code = ALU_SLLV;
          FN_SRLV: code = ALU_SRLV;
          FN_SLT:  code = ALU_SLT;
          FN_MFHI: begin code = ALU_MFHI; isHiloRd = 1'b1; end
          FN_MFLO: begin code = ALU_MFLO; isHiloRd = 1'b1; end
          default: illegal = 1'b1;
        endcase
      ALUOP_ADDI: code = ALU_ADD;
      ALUOP_ANDI: code = ALU_AND;
      ALUOP_ORI:  code = ALU_OR;
      ALUOP_XORI: code = ALU_XOR;
      ALUOP_BEQ:  code = ALU_SUB;
      ALUOP_BNE:  code = ALU_BNE;
      ALUOP_BLEZ: code = ALU_BLEZ;
      ALUOP_BGTZ: code = ALU_BGTZ;
      ALUOP_LUI:  code = ALU_LUI;
      ALUOP_SLTI: code = ALU_SLTI;
      default:    illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode plus mult/div sequencer with HI/LO interlock
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 6,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [3:0]        AluOp,
  input  logic [5:0]        FnField,
  input  logic              flush,
  output logic [CTRL_W-1:0] AluCtrl,
  output logic              ctrl_valid,
  output logic              illegal,
  output logic              md_start,
  output logic              md_is_div,
  output logic              hilo_we,
  output logic              busy,
  output logic              stall
);
  logic [4:0] decCode;
  logic decIllegal, decMult, decDiv, decHiloRd, accept;
  seq_state_e state;
  logic [CNT_W-1:0] cnt;

  alu_ctrl_decode u_decode (
    .aluOp(AluOp),
    .fnField(FnField),
    .code(decCode),
    .illegal(decIllegal),
    .isMult(decMult),
    .isDiv(decDiv),
    .isHiloRd(decHiloRd)
  );

  assign busy = state != S_IDLE;
  assign stall = op_valid & ~flush & (decMult | decDiv | decHiloRd) & busy;
  assign accept = op_valid & ~flush & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      AluCtrl <= '0;
      ctrl_valid <= 1'b0;
      illegal <= 1'b0;
      md_start <= 1'b0;
      md_is_div <= 1'b0;
      hilo_we <= 1'b0;
      state <= S_IDLE;
      cnt <= '0;
    end else if (flush) begin
      ctrl_valid <= 1'b0;
      md_start <= 1'b0;
      hilo_we <= 1'b0;
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      ctrl_valid <= accept;
      md_start <= 1'b0;
      hilo_we <= 1'b0;
      if (accept) begin
        AluCtrl <= CTRL_W'(decCode);
        illegal <= decIllegal;
      end
      // mult/div only reach here from IDLE since they stall otherwise
      case (state)
        S_IDLE:
          if (accept & (decMult | decDiv)) begin
            state <= S_BUSY;
            cnt <= decDiv ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            md_is_div <= decDiv;
            md_start <= 1'b1;
          end
        S_BUSY:
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
            cnt <= '0;
            hilo_we <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: scoreboard bench for decode table, mult/div sequencing, interlock, flush and reset
module tb_alu_ctrl_seq;
  logic clk = 1'b0;
  logic reset, op_valid, flush;
  logic [3:0] AluOp;
  logic [5:0] FnField;
  logic [5:0] AluCtrl;
  logic ctrl_valid, illegal, md_start, md_is_div, hilo_we, busy, stall;
  logic [7:0] AluCtrl2;
  logic ctrl_valid2, illegal2, md_start2, md_is_div2, hilo_we2, busy2, stall2;
  int total = 0;
  int bad = 0;
  logic [6:0] sbq[$];

  typedef struct packed {
    logic [3:0] op;
    logic [5:0] fn;
    logic [4:0] code;
    logic       ill;
  } vec_t;

  localparam int NV = 26;
  localparam vec_t VECS[NV] = '{
    '{4'b1000, 6'b100100, 5'b00000, 1'b0},
    '{4'b1000, 6'b100101, 5'b00010, 1'b0},
    '{4'b1000, 6'b100110, 5'b00110, 1'b0},
    '{4'b1000, 6'b100111, 5'b11000, 1'b0},
    '{4'b1000, 6'b100000, 5'b00100, 1'b0},
    '{4'b1000, 6'b100010, 5'b01100, 1'b0},
    '{4'b1000, 6'b000000, 5'b10000, 1'b0},
    '{4'b1000, 6'b000010, 5'b10010, 1'b0},
    '{4'b1000, 6'b000011, 5'b10100, 1'b0},
    '{4'b1000, 6'b000100, 5'b10110, 1'b0},
    '{4'b1000, 6'b000110, 5'b11001, 1'b0},
    '{4'b1000, 6'b101010, 5'b01110, 1'b0},
    '{4'b1000, 6'b010000, 5'b01111, 1'b0},
    '{4'b1000, 6'b010010, 5'b00001, 1'b0},
    '{4'b1000, 6'b111111, 5'b00000, 1'b1},
    '{4'b0101, 6'b000000, 5'b00000, 1'b1},
    '{4'b0000, 6'b101010, 5'b00100, 1'b0},
    '{4'b0001, 6'b000000, 5'b00000, 1'b0},
    '{4'b0010, 6'b000000, 5'b00010, 1'b0},
    '{4'b0011, 6'b000000, 5'b00110, 1'b0},
    '{4'b0100, 6'b000000, 5'b01100, 1'b0},
    '{4'b0110, 6'b000000, 5'b11010, 1'b0},
    '{4'b0111, 6'b000000, 5'b11100, 1'b0},
    '{4'b1001, 6'b000000, 5'b11110, 1'b0},
    '{4'b1010, 6'b000000, 5'b00011, 1'b0},
    '{4'b1011, 6'b011000, 5'b00111, 1'b0}
  };

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .AluOp(AluOp), .FnField(FnField),
    .flush(flush), .AluCtrl(AluCtrl), .ctrl_valid(ctrl_valid), .illegal(illegal),
    .md_start(md_start), .md_is_div(md_is_div), .hilo_we(hilo_we), .busy(busy), .stall(stall)
  );

  alu_ctrl_seq #(.CTRL_W(8), .MULT_LAT(1)) dut2 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .AluOp(AluOp), .FnField(FnField),
    .flush(flush), .AluCtrl(AluCtrl2), .ctrl_valid(ctrl_valid2), .illegal(illegal2),
    .md_start(md_start2), .md_is_div(md_is_div2), .hilo_we(hilo_we2), .busy(busy2), .stall(stall2)
  );

  always @(negedge clk) begin
    if (ctrl_valid === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got ctrl=%b ill=%b with nothing expected", AluCtrl, illegal);
      end else begin
        logic [6:0] e;
        e = sbq.pop_front();
        if ({AluCtrl, illegal} !== e) begin
          bad++;
          $display("FAIL sb_ctrl: got ctrl=%b ill=%b expected ctrl=%b ill=%b", AluCtrl, illegal, e[6:1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [5:0] fn);
    op_valid = 1'b1;
    AluOp = op;
    FnField = fn;
  endtask

  task automatic expect_op(input logic [4:0] code, input logic ill);
    sbq.push_back({1'b0, code, ill});
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; flush = 1'b0; AluOp = 4'b0; FnField = 6'b0;
    tick(); tick();
    chk("rst_aluctrl", 32'(AluCtrl), 0);
    chk("rst_valid", 32'(ctrl_valid), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_md_start", 32'(md_start), 0);
    chk("rst_md_is_div", 32'(md_is_div), 0);
    chk("rst_hilo_we", 32'(hilo_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(stall), 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < NV; i++) begin
      issue(VECS[i].op, VECS[i].fn);
      expect_op(VECS[i].code, VECS[i].ill);
      tick();
    end
    op_valid = 1'b0;
    tick(); tick();
    chk("hold_aluctrl", 32'(AluCtrl), 32'h07);
    chk("hold_illegal", 32'(illegal), 0);
    chk("hold_valid", 32'(ctrl_valid), 0);

    issue(4'b1000, 6'b011000);
    expect_op(5'b01000, 1'b0);
    tick();
    op_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("mult_busy_t%0d", k), 32'(busy), 32'(k <= 5));
      chk($sformatf("mult_hilo_t%0d", k), 32'(hilo_we), 32'(k == 5));
      chk($sformatf("mult_start_t%0d", k), 32'(md_start), 32'(k == 1));
      if (k == 1) chk("mult_is_div", 32'(md_is_div), 0);
      tick();
    end

    issue(4'b1000, 6'b011010);
    expect_op(5'b01010, 1'b0);
    tick();
    for (int k = 1; k <= 34; k++) begin
      chk($sformatf("div_busy_t%0d", k), 32'(busy), 32'(k <= 33));
      chk($sformatf("div_hilo_t%0d", k), 32'(hilo_we), 32'(k == 33));
      chk($sformatf("div_start_t%0d", k), 32'(md_start), 32'(k == 1));
      if (k == 1) chk("div_is_div", 32'(md_is_div), 1);
      issue(4'b1000, k == 3 ? 6'b100000 : 6'b010000);
      #1;
      chk($sformatf("div_stall_t%0d", k), 32'(stall), 32'(k != 3 && k <= 33));
      if (k == 3) expect_op(5'b00100, 1'b0);
      if (k == 34) expect_op(5'b01111, 1'b0);
      tick();
    end
    op_valid = 1'b0;
    tick();

    issue(4'b1000, 6'b011000);
    expect_op(5'b01000, 1'b0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      issue(4'b1000, 6'b011000);
      #1;
      chk($sformatf("b2b_stall_t%0d", k), 32'(stall), 32'(k <= 5));
      if (k == 6) expect_op(5'b01000, 1'b0);
      tick();
    end
    op_valid = 1'b0;
    chk("b2b_start", 32'(md_start), 1);
    chk("b2b_busy", 32'(busy), 1);
    repeat (6) tick();
    chk("b2b_idle", 32'(busy), 0);

    issue(4'b1000, 6'b011000);
    expect_op(5'b01000, 1'b0);
    tick();
    op_valid = 1'b0;
    tick();
    flush = 1'b1;
    issue(4'b1000, 6'b100000);
    #1;
    chk("flush_stall", 32'(stall), 0);
    tick();
    flush = 1'b0;
    op_valid = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_valid", 32'(ctrl_valid), 0);
    chk("flush_aluctrl_hold", 32'(AluCtrl), 32'h08);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("flush_hilo_%0d", k), 32'(hilo_we), 0);
      tick();
    end

    issue(4'b1000, 6'b011000);
    expect_op(5'b01000, 1'b0);
    tick();
    op_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_aluctrl", 32'(AluCtrl), 0);
    chk("rstmid_valid", 32'(ctrl_valid), 0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rstmid_hilo_%0d", k), 32'(hilo_we), 0);
      tick();
    end

    issue(4'b1000, 6'b011000);
    expect_op(5'b01000, 1'b0);
    tick();
    op_valid = 1'b0;
    begin
      logic [7:0] a2;
      a2 = AluCtrl2;
      chk("w8_aluctrl", 32'(a2), 32'h08);
      chk("w8_upper", 32'(a2[7:5]), 0);
    end
    chk("l1_start_t1", 32'(md_start2), 1);
    chk("l1_busy_t1", 32'(busy2), 1);
    chk("l1_hilo_t1", 32'(hilo_we2), 0);
    tick();
    chk("l1_busy_t2", 32'(busy2), 1);
    chk("l1_hilo_t2", 32'(hilo_we2), 1);
    tick();
    chk("l1_busy_t3", 32'(busy2), 0);
    chk("l1_hilo_t3", 32'(hilo_we2), 0);
    repeat (6) tick();
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
